// File: rtl/cs_measurement_buffer_if.sv
// cs_measurement_buffer_if
// Valid/ready sample stream from the measurement buffer to the
// transmit/packing stage.
//   valid : sample on data/idx/last/sat is valid (source -> sink)
//   ready : sink accepts the sample when high together with valid
//   data  : signed scaled/saturated measurement
//   idx   : index of data within the frame
//   last  : high with the final sample of the frame
//   sat   : high when data was clipped
// Modports: master = producing side (buffer), slave = consuming side.
interface cs_measurement_buffer_if #(
  parameter int OUT_W  = 12,
  parameter int ADDR_W = 9
);
  logic                     valid;
  logic                     ready;
  logic signed [OUT_W-1:0]  data;
  logic [ADDR_W-1:0]        idx;
  logic                     last;
  logic                     sat;

  modport master (output valid, data, idx, last, sat, input ready);
  modport slave  (input valid, data, idx, last, sat, output ready);
endinterface

// File: rtl/cs_measurement_buffer.sv
// cs_measurement_buffer
// Ping-pong capture of compressed-sensing measurements. The encoder writes
// one frame of M signed values into the write bank; on frame_done the banks
// swap and the completed frame is read back, shifted right arithmetically by
// SHIFT, saturated to OUT_W bits and streamed out one sample per handshake.
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous active-low reset
//   we/addr/y_in : encoder measurement write into the current write bank
//   frame_done : one-cycle pulse, current frame complete
//   sample_bus : valid/ready output stream (master side)
//   drop_cnt   : saturating count of frames dropped while the reader was busy
module cs_measurement_buffer #(
  parameter int M      = 512,
  parameter int ADDR_W = 9,
  parameter int IN_W   = 17,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic signed [IN_W-1:0]  y_in,
  input  logic                    frame_done,
  cs_measurement_buffer_if.master sample_bus,
  output logic [7:0]              drop_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(M - 1);
  // Saturation bounds expressed at the input width so the comparison is
  // done on the full shifted value.
  localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t state, state_next;
  logic wb, rb;
  logic [ADDR_W-1:0] idx;
  logic addr_ok;

  logic signed [IN_W-1:0] bank0 [M];
  logic signed [IN_W-1:0] bank1 [M];
  logic signed [IN_W-1:0] rd0, rd1;
  logic signed [IN_W-1:0] rd_word, shifted;
  logic signed [OUT_W-1:0] scaled;
  logic clip;

  // When M fills the address space every address is in range, so the
  // bounds check only exists for non-power-of-two frame sizes.
  if (M < (2 ** ADDR_W)) begin : g_range_check
    assign addr_ok = ({1'b0, addr} < (ADDR_W+1)'(M));
  end else begin : g_full_range
    assign addr_ok = 1'b1;
  end

  // One write port and one registered read port per bank so each bank maps
  // onto a block RAM. Writes use the pre-swap wb, so a write coinciding with
  // frame_done lands in the frame being completed. Contents are never reset.
  always_ff @(posedge clk) begin
    if (we && addr_ok && !wb) bank0[addr] <= y_in;
    if (state == FETCH) rd0 <= bank0[idx];
  end

  always_ff @(posedge clk) begin
    if (we && addr_ok && wb) bank1[addr] <= y_in;
    if (state == FETCH) rd1 <= bank1[idx];
  end

  // Scale by arithmetic shift (rounds toward negative infinity), then clip.
  always_comb begin
    rd_word = rb ? rd1 : rd0;
    shifted = rd_word >>> SHIFT;
    scaled  = shifted[OUT_W-1:0];
    clip    = 1'b0;
    if (shifted > SAT_MAX) begin
      scaled = SAT_MAX[OUT_W-1:0];
      clip   = 1'b1;
    end else if (shifted < SAT_MIN) begin
      scaled = SAT_MIN[OUT_W-1:0];
      clip   = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_done) state_next = FETCH;
      FETCH:   state_next = LOAD;
      LOAD:    state_next = HOLD;
      HOLD:    if (sample_bus.valid && sample_bus.ready)
                 state_next = (idx == LAST_IDX) ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      wb               <= 1'b0;
      rb               <= 1'b0;
      idx              <= '0;
      drop_cnt         <= '0;
      sample_bus.valid <= 1'b0;
      sample_bus.data  <= '0;
      sample_bus.idx   <= '0;
      sample_bus.last  <= 1'b0;
      sample_bus.sat   <= 1'b0;
    end else begin
      state <= state_next;
      // A busy reader drops the new frame; wb stays put so the next frame
      // simply overwrites the dropped one.
      if (frame_done) begin
        if (state == IDLE) begin
          rb  <= wb;
          wb  <= ~wb;
          idx <= '0;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
      if (state == LOAD) begin
        sample_bus.valid <= 1'b1;
        sample_bus.data  <= scaled;
        sample_bus.idx   <= idx;
        sample_bus.last  <= (idx == LAST_IDX);
        sample_bus.sat   <= clip;
      end
      if (state == HOLD && sample_bus.valid && sample_bus.ready) begin
        sample_bus.valid <= 1'b0;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cs_measurement_buffer.sv
// tb_cs_measurement_buffer
// Directed bench for cs_measurement_buffer. A second instance with SHIFT=2
// shares the write side so that clipping can actually occur.
module tb_cs_measurement_buffer;

  localparam int M = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               we;
  logic [8:0]         addr;
  logic signed [16:0] y_in;
  logic               frame_done;
  logic [7:0]         drop_cnt;
  logic [7:0]         drop_cnt2;

  cs_measurement_buffer_if #(.OUT_W(12), .ADDR_W(9)) bus ();
  cs_measurement_buffer_if #(.OUT_W(12), .ADDR_W(9)) bus2 ();

  assign bus2.ready = 1'b1;

  cs_measurement_buffer #(.M(M), .ADDR_W(9), .IN_W(17), .OUT_W(12), .SHIFT(5)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .y_in(y_in),
    .frame_done(frame_done), .sample_bus(bus), .drop_cnt(drop_cnt)
  );

  cs_measurement_buffer #(.M(M), .ADDR_W(9), .IN_W(17), .OUT_W(12), .SHIFT(2)) dut_sat (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .y_in(y_in),
    .frame_done(frame_done), .sample_bus(bus2), .drop_cnt(drop_cnt2)
  );

  int checks = 0;
  int errors = 0;
  int exp_data [M];
  bit exp_sat  [M];
  int exp2_data [8];
  bit exp2_sat  [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes y = (slope*k + offset)*32 so the SHIFT=5 output is exactly
  // slope*k + offset.
  task automatic write_ramp(input int slope, input int offset, input int count, input bit set_exp);
    for (int k = 0; k < count; k++) begin
      we   = 1'b1;
      addr = 9'(k);
      y_in = 17'((slope * k + offset) * 32);
      if (set_exp) begin
        exp_data[k] = slope * k + offset;
        exp_sat[k]  = 1'b0;
      end
      tick();
    end
    we = 1'b0;
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  // Consumes samples with ready high from index start to M-1.
  task automatic drain(input int start, input bit chk2);
    int n = start;
    int budget = 3 * M + 60;
    bit done = 1'b0;
    bus.ready = 1'b1;
    while (!done && budget > 0) begin
      if (bus.valid === 1'b1) begin
        checks++;
        if (bus.idx !== 9'(n)) begin
          errors++;
          $display("[TB] FAIL drain_idx: got %0d, expected %0d", bus.idx, n);
        end
        checks++;
        if (bus.data !== 12'(exp_data[n])) begin
          errors++;
          $display("[TB] FAIL drain_data[%0d]: got %0d, expected %0d", n, $signed(bus.data), exp_data[n]);
        end
        checks++;
        if (bus.last !== (n == M - 1)) begin
          errors++;
          $display("[TB] FAIL drain_last[%0d]: got %0b, expected %0b", n, bus.last, (n == M - 1));
        end
        checks++;
        if (bus.sat !== exp_sat[n]) begin
          errors++;
          $display("[TB] FAIL drain_sat[%0d]: got %0b, expected %0b", n, bus.sat, exp_sat[n]);
        end
        if (chk2 && n < 8) begin
          checks++;
          if (bus2.valid !== 1'b1 || bus2.data !== 12'(exp2_data[n]) || bus2.sat !== exp2_sat[n]) begin
            errors++;
            $display("[TB] FAIL clip_dut[%0d]: got valid %0b data %0d sat %0b, expected valid 1 data %0d sat %0b",
                     n, bus2.valid, $signed(bus2.data), bus2.sat, exp2_data[n], exp2_sat[n]);
          end
        end
        if (n >= M - 1) done = 1'b1;
        n++;
      end
      tick();
      budget--;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d samples, expected %0d", n - start, M - start);
    end
  endtask

  task automatic test_reset();
    int seen = 0;
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b, expected 0", bus.valid); end
    checks++; if (bus.last  !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %0b, expected 0", bus.last); end
    checks++; if (bus.sat   !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat: got %0b, expected 0", bus.sat); end
    checks++; if (bus.data  !== 12'd0) begin errors++; $display("[TB] FAIL reset_data: got %0d, expected 0", bus.data); end
    checks++; if (bus.idx   !== 9'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d, expected 0", bus.idx); end
    checks++; if (drop_cnt  !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt: got %0d, expected 0", drop_cnt); end
    reset = 1'b1;
    bus.ready = 1'b1;
    repeat (5) begin
      tick();
      if (bus.valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL idle_no_output: got %0d valid cycles, expected 0", seen); end
  endtask

  task automatic test_basic_frame();
    int gap = 0;
    write_ramp(1, 0, M, 1'b1);
    pulse_done();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge1: got %0b, expected 0", bus.valid); end
    tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge2: got %0b, expected 0", bus.valid); end
    tick();
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_edge3: got %0b, expected 1", bus.valid); end
    checks++; if (bus.idx !== 9'd0 || bus.data !== 12'd0) begin
      errors++; $display("[TB] FAIL first_sample: got idx %0d data %0d, expected idx 0 data 0", bus.idx, bus.data);
    end
    // Sample 0 transfers on the next edge; sample 1 must follow 3 edges later.
    tick();
    gap = 1;
    while (bus.valid !== 1'b1 && gap < 10) begin
      tick();
      gap++;
    end
    checks++; if (gap != 3) begin errors++; $display("[TB] FAIL sample_period: got %0d cycles, expected 3", gap); end
    drain(1, 1'b0);
  endtask

  task automatic test_rounding();
    int rnd_y [8];
    int rnd_o [8];
    rnd_y = '{65535, -65536, -1, -33, 31, 8188, 8192, -8196};
    rnd_o = '{2047, -2048, -1, -2, 0, 255, 256, -257};
    exp2_data = '{2047, -2048, -1, -9, 7, 2047, 2047, -2048};
    exp2_sat  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    write_ramp(0, 0, M, 1'b1);
    for (int k = 0; k < 8; k++) begin
      we   = 1'b1;
      addr = 9'(k);
      y_in = 17'(rnd_y[k]);
      exp_data[k] = rnd_o[k];
      exp_sat[k]  = 1'b0;
      tick();
    end
    we = 1'b0;
    pulse_done();
    drain(0, 1'b1);
  endtask

  task automatic test_backpressure();
    int budget = 60;
    int bad = 0;
    write_ramp(1, 0, M, 1'b1);
    bus.ready = 1'b1;
    pulse_done();
    while (!(bus.valid === 1'b1 && bus.idx === 9'd3) && budget > 0) begin
      tick();
      budget--;
    end
    bus.ready = 1'b0;
    checks++; if (budget == 0) begin errors++; $display("[TB] FAIL bp_reach_idx3: got timeout, expected idx 3"); end
    repeat (10) begin
      tick();
      if (bus.valid !== 1'b1 || bus.idx !== 9'd3 || bus.data !== 12'd3) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable cycles, expected 0", bad); end
    bus.ready = 1'b1;
    tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_single_transfer: got valid %0b, expected 0", bus.valid); end
    budget = 10;
    while (bus.valid !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    checks++; if (bus.idx !== 9'd4 || bus.data !== 12'd4) begin
      errors++; $display("[TB] FAIL bp_next_idx: got idx %0d data %0d, expected idx 4 data 4", bus.idx, bus.data);
    end
    drain(4, 1'b0);
  endtask

  task automatic test_ping_pong_drop();
    int seen = 0;
    write_ramp(-1, 0, M, 1'b1);
    pulse_done();
    fork
      drain(0, 1'b0);
      begin
        write_ramp(0, 7, M, 1'b0);
        pulse_done();
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL drop_count: got %0d, expected 1", drop_cnt); end
      end
    join
    repeat (10) begin
      tick();
      if (bus.valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL dropped_frame_streamed: got %0d valid cycles, expected 0", seen); end
    // Frame C: the last write coincides with frame_done.
    write_ramp(1, -256, M - 1, 1'b1);
    we = 1'b1;
    addr = 9'd511;
    y_in = 17'(1500 * 32);
    exp_data[511] = 1500;
    exp_sat[511]  = 1'b0;
    frame_done = 1'b1;
    tick();
    we = 1'b0;
    frame_done = 1'b0;
    drain(0, 1'b0);
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL drop_count_after_c: got %0d, expected 1", drop_cnt); end
  endtask

  task automatic test_reset_mid_stream();
    int budget = 200;
    int seen = 0;
    write_ramp(1, 0, M, 1'b1);
    bus.ready = 1'b1;
    frame_done = 1'b1;
    repeat (261) tick();
    frame_done = 1'b0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL drop_saturate: got %0d, expected 255", drop_cnt); end
    while (!(bus.valid === 1'b1 && bus.idx === 9'd100) && budget > 0) begin
      tick();
      budget--;
    end
    checks++; if (budget == 0) begin errors++; $display("[TB] FAIL mid_reach_idx100: got timeout, expected idx 100"); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %0b, expected 0", bus.valid); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset_drop_cnt: got %0d, expected 0", drop_cnt); end
    checks++; if (bus.idx !== 9'd0) begin errors++; $display("[TB] FAIL mid_reset_idx: got %0d, expected 0", bus.idx); end
    repeat (20) begin
      tick();
      if (bus.valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL post_reset_quiet: got %0d valid cycles, expected 0", seen); end
    write_ramp(1, -100, M, 1'b1);
    pulse_done();
    drain(0, 1'b0);
  endtask

  initial begin
    reset      = 1'b0;
    we         = 1'b0;
    addr       = '0;
    y_in       = '0;
    frame_done = 1'b0;
    bus.ready  = 1'b0;
    $display("[TB] starting cs_measurement_buffer bench");
    test_reset();
    test_basic_frame();
    test_rounding();
    test_backpressure();
    test_ping_pong_drop();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
